// File: rtl/pulse_capture.sv
// pulse_capture
//   Multi-channel asynchronous pulse/edge capture. Each channel synchronises
//   its input, detects edges according to a common mode, and produces a
//   one-cycle strobe. The strobe also drives a retriggerable stretched output,
//   a sticky flag and an optional saturating event counter.
//
//   Build option: define PULSE_CAPTURE_CNT_EN to build the per-channel event
//   counters. Without it, no counter state exists and cnt is tied to zero.
//
//   Parameters
//     WIDTH        number of independent channels
//     SYNC_STAGES  synchroniser depth per channel (>= 2)
//     STRETCH      stretched-output length in clk cycles (>= 1)
//     CNT_W        per-channel event-counter width
//
//   Ports
//     clk      single clock, rising edge
//     reset    synchronous, active-high reset
//     d        asynchronous pulse inputs, one per channel
//     mode     00 rising, 01 falling, 10 both edges, 11 disabled
//     clr      per-channel clear of sticky flag and counter
//     pulse    one-cycle detect strobe per channel
//     stretch  detect stretched to STRETCH cycles, retriggerable
//     sticky   latched detect flag
//     cnt      channel i count in bits [i*CNT_W +: CNT_W]
//     busy     OR of all stretch outputs
module pulse_capture #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 3,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       d,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       clr,
   output logic [WIDTH-1:0]       pulse,
   output logic [WIDTH-1:0]       stretch,
   output logic [WIDTH-1:0]       sticky,
   output logic [WIDTH*CNT_W-1:0] cnt,
   output logic                   busy
);

   localparam int SCNT_W = $clog2(STRETCH + 1);

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;

   logic [SYNC_STAGES-1:0] sync_q [WIDTH];
   logic [SCNT_W-1:0]      scnt_q [WIDTH];
   logic [WIDTH-1:0]       hist_q;
   logic [WIDTH-1:0]       sync_last;
   logic [WIDTH-1:0]       det;

   always_comb begin
      sync_last = '0;
      for (int unsigned ch = 0; ch < WIDTH; ch++) begin
         sync_last[ch] = sync_q[ch][SYNC_STAGES-1];
      end
   end

   // The synchronisers and history flops run regardless of mode, so the
   // history always matches the last synchronised value and switching mode
   // can never manufacture an edge.
   always_comb begin
      det = '0;
      case (mode)
         MODE_RISE: det = sync_last & ~hist_q;
         MODE_FALL: det = ~sync_last & hist_q;
         MODE_BOTH: det = sync_last ^ hist_q;
         default:   det = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned ch = 0; ch < WIDTH; ch++) begin
            sync_q[ch] <= '0;
            scnt_q[ch] <= '0;
         end
         hist_q <= '0;
         pulse  <= '0;
         sticky <= '0;
      end else begin
         for (int unsigned ch = 0; ch < WIDTH; ch++) begin
            sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], d[ch]};
            // Loaded from the same detect that sets pulse, so stretch rises
            // together with the strobe; a new detect simply reloads.
            if (det[ch]) begin
               scnt_q[ch] <= SCNT_W'(STRETCH);
            end else if (scnt_q[ch] != '0) begin
               scnt_q[ch] <= scnt_q[ch] - SCNT_W'(1);
            end
         end
         hist_q <= sync_last;
         pulse  <= det;
         // Driven by the registered strobe: a clr issued in the strobe cycle
         // lands on the same edge as the detect and the detect wins.
         sticky <= pulse | (sticky & ~clr);
      end
   end

   always_comb begin
      stretch = '0;
      for (int unsigned ch = 0; ch < WIDTH; ch++) begin
         stretch[ch] = (scnt_q[ch] != '0);
      end
   end

   assign busy = |stretch;

`ifdef PULSE_CAPTURE_CNT_EN
   logic [CNT_W-1:0] cnt_q [WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned ch = 0; ch < WIDTH; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         for (int unsigned ch = 0; ch < WIDTH; ch++) begin
            if (clr[ch]) begin
               cnt_q[ch] <= pulse[ch] ? CNT_W'(1) : '0;
            end else if (pulse[ch] && (cnt_q[ch] != '1)) begin
               cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int unsigned ch = 0; ch < WIDTH; ch++) begin
         cnt[ch*CNT_W +: CNT_W] = cnt_q[ch];
      end
   end
`else
   assign cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture
//   Bench for pulse_capture at default parameters. A behavioural model keeps
//   the sampled input history per channel and derives every output from it;
//   one process compares all outputs after every clock edge. Directed
//   sequences add literal expectations; a randomized phase follows.
//   Honours PULSE_CAPTURE_CNT_EN the same way the design does.
module tb_pulse_capture;

   localparam int W  = 4;
   localparam int S  = 2;
   localparam int ST = 3;
   localparam int CW = 8;
`ifdef PULSE_CAPTURE_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [W-1:0]    d;
   logic [1:0]      mode;
   logic [W-1:0]    clr;
   logic [W-1:0]    pulse;
   logic [W-1:0]    stretch;
   logic [W-1:0]    sticky;
   logic [W*CW-1:0] cnt;
   logic            busy;

   int n_assert = 0;
   int n_fail   = 0;

   pulse_capture #(
      .WIDTH      (W),
      .SYNC_STAGES(S),
      .STRETCH    (ST),
      .CNT_W      (CW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .d      (d),
      .mode   (mode),
      .clr    (clr),
      .pulse  (pulse),
      .stretch(stretch),
      .sticky (sticky),
      .cnt    (cnt),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [CW-1:0] cnt_of(input int ch);
      return cnt[ch*CW +: CW];
   endfunction

   // ---------------- behavioural model ----------------
   // samp[ch][k] is the level sampled k edges ago (k=0 newest); a reset edge
   // wipes the history to zero. The strobe after edge n compares the samples
   // taken S and S+1 edges earlier.
   bit samp     [W][S+2];
   bit m_pulse  [W];
   bit m_sticky [W];
   bit has_det  [W];
   int m_cnt    [W];
   int last_det [W];
   int edge_n = 0;

   logic [W-1:0]    e_pulse, e_stretch, e_sticky;
   logic [W*CW-1:0] e_cnt;

   always @(posedge clk) begin : model
      logic         r;
      logic [W-1:0] dd, cl;
      logic [1:0]   md;
      bit           nw, od, dt;
      r  = reset;
      dd = d;
      cl = clr;
      md = mode;
      edge_n++;
      for (int ch = 0; ch < W; ch++) begin
         if (r) begin
            for (int j = 0; j < S + 2; j++) samp[ch][j] = 1'b0;
            m_pulse[ch]  = 1'b0;
            m_sticky[ch] = 1'b0;
            has_det[ch]  = 1'b0;
            m_cnt[ch]    = 0;
         end else begin
            for (int j = S + 1; j > 0; j--) samp[ch][j] = samp[ch][j-1];
            samp[ch][0] = dd[ch];
            nw = samp[ch][S];
            od = samp[ch][S+1];
            case (md)
               2'b00:   dt = nw && !od;
               2'b01:   dt = !nw && od;
               2'b10:   dt = nw != od;
               default: dt = 1'b0;
            endcase
            m_sticky[ch] = m_pulse[ch] || (m_sticky[ch] && !cl[ch]);
            if (cl[ch])           m_cnt[ch] = m_pulse[ch] ? 1 : 0;
            else if (m_pulse[ch]) m_cnt[ch] = (m_cnt[ch] < CMAX) ? m_cnt[ch] + 1 : CMAX;
            m_pulse[ch] = dt;
            if (dt) begin
               has_det[ch]  = 1'b1;
               last_det[ch] = edge_n;
            end
         end
         e_pulse[ch]   = m_pulse[ch];
         e_stretch[ch] = has_det[ch] && ((edge_n - last_det[ch]) < ST);
         e_sticky[ch]  = m_sticky[ch];
         e_cnt[ch*CW +: CW] = (CNT_ON != 0) ? CW'(m_cnt[ch]) : '0;
      end
      #1;
      check("pulse",   pulse,   e_pulse);
      check("stretch", stretch, e_stretch);
      check("sticky",  sticky,  e_sticky);
      check("cnt",     cnt,     e_cnt);
      check("busy",    busy,    |e_stretch);
   end

   // ---------------- stimulus helpers ----------------
   // Caller raises d[ch] just before; records 8 negedge samples of
   // pulse/stretch, optionally dropping d[ch] after one cycle.
   task automatic record(input int ch, input bit drop,
                         output logic [7:0] p, output logic [7:0] s);
      p = '0;
      s = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         p[k-1] = pulse[ch];
         s[k-1] = stretch[ch];
         if (k == 1 && drop) d[ch] = 1'b0;
      end
   endtask

   task automatic clear_ch(input int ch);
      clr[ch] = 1'b1;
      @(negedge clk);
      clr[ch] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] p, s;
      int gaps;
      d     = '0;
      mode  = 2'b00;
      clr   = '0;
      reset = 1'b1;
      #12 reset = 1'b0;
      @(negedge clk);

      // single one-cycle pulse on ch0 under each mode
      mode = 2'b00; d[0] = 1'b1; record(0, 1'b1, p, s);
      check("m00_pulse_trace",   p, 8'b0000_0100);
      check("m00_stretch_trace", s, 8'b0001_1100);
      check("m00_sticky", sticky[0], 1);
      check("m00_cnt0",   cnt_of(0), CNT_ON * 1);
      clear_ch(0);

      mode = 2'b01; d[0] = 1'b1; record(0, 1'b1, p, s);
      check("m01_pulse_trace",   p, 8'b0000_1000);
      check("m01_stretch_trace", s, 8'b0011_1000);
      check("m01_cnt0",   cnt_of(0), CNT_ON * 1);
      clear_ch(0);

      mode = 2'b10; d[0] = 1'b1; record(0, 1'b1, p, s);
      check("m10_pulse_trace",   p, 8'b0000_1100);
      check("m10_stretch_trace", s, 8'b0011_1100);
      check("m10_cnt0",   cnt_of(0), CNT_ON * 2);
      clear_ch(0);

      mode = 2'b11; d[0] = 1'b1; record(0, 1'b1, p, s);
      check("m11_pulse_trace",   p, 8'b0);
      check("m11_stretch_trace", s, 8'b0);
      check("m11_sticky", sticky[0], 0);
      check("m11_cnt0",   cnt_of(0), 0);
      mode = 2'b00;

      // 300-pulse burst on ch1: saturation and continuous stretch
      gaps = 0;
      for (int i = 0; i < 300; i++) begin
         d[1] = 1'b1;
         @(negedge clk);
         if (i >= 2 && !stretch[1]) gaps++;
         d[1] = 1'b0;
         @(negedge clk);
         if (i >= 2 && !stretch[1]) gaps++;
      end
      repeat (4) @(negedge clk);
      check("burst_stretch_gaps", gaps, 0);
      check("burst_cnt1",   cnt_of(1), CNT_ON * 255);
      check("burst_sticky1", sticky[1], 1);

      // clr coinciding with the ch2 strobe, then clr alone
      d[2] = 1'b1;
      @(negedge clk); d[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ch2_strobe", pulse[2], 1);
      clr[2] = 1'b1;
      @(negedge clk); clr[2] = 1'b0;
      check("ch2_clr_hit_sticky", sticky[2], 1);
      check("ch2_clr_hit_cnt",    cnt_of(2), CNT_ON * 1);
      clr[2] = 1'b1;
      @(negedge clk); clr[2] = 1'b0;
      check("ch2_clr_sticky", sticky[2], 0);
      check("ch2_clr_cnt",    cnt_of(2), 0);

      // reset mid-stretch on ch3 with cnt3=5, d3 held high across release
      for (int i = 0; i < 5; i++) begin
         d[3] = 1'b1;
         @(negedge clk);
         d[3] = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      check("ch3_pre_stretch", stretch[3], 1);
      check("ch3_pre_cnt",     cnt_of(3), CNT_ON * 5);
      reset = 1'b1;
      d[3]  = 1'b1;
      @(negedge clk);
      check("rst_pulse",   pulse,   0);
      check("rst_stretch", stretch, 0);
      check("rst_sticky",  sticky,  0);
      check("rst_cnt",     cnt,     0);
      check("rst_busy",    busy,    0);
      reset = 1'b0;
      record(3, 1'b0, p, s);
      check("rel_pulse_trace",   p, 8'b0000_0100);
      check("rel_stretch_trace", s, 8'b0001_1100);
      d[3] = 1'b0;
      repeat (4) @(negedge clk);

      // randomized phase, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) == 0)  d = W'($urandom);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         clr   = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         reset = ($urandom_range(0, 299) == 0);
      end
      reset = 1'b0;
      clr   = '0;
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_capture.md
PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of independent input channels.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, minimum 2: synchroniser depth per channel.
REQ-003 SHALL provide parameter STRETCH, default 3, minimum 1: stretched-output length in clk cycles.
REQ-004 SHALL provide parameter CNT_W, default 8: per-channel event-counter width.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL provide port d, input, WIDTH bits: asynchronous pulse inputs, one per channel.
REQ-008 SHALL provide port mode, input, 2 bits: detection mode, common to all channels (00 rising, 01 falling, 10 both, 11 disabled).
REQ-009 SHALL provide port clr, input, WIDTH bits: per-channel clear of sticky flag and counter.
REQ-010 SHALL provide port pulse, output, WIDTH bits: one-cycle detect strobe per channel.
REQ-011 SHALL provide port stretch, output, WIDTH bits: detect stretched to STRETCH cycles.
REQ-012 SHALL provide port sticky, output, WIDTH bits: latched detect flag.
REQ-013 SHALL provide port cnt, output, WIDTH*CNT_W bits: channel i count in bits [i*CNT_W +: CNT_W].
REQ-014 SHALL provide port busy, output, 1 bit: OR-reduction of stretch.

Function
REQ-015 Each channel SHALL pass d[i] through a SYNC_STAGES-flop chain, then a history flop holding the previous synchronised value.
REQ-016 Detect SHALL be computed from the last sync stage and the history flop, according to mode; mode 11 SHALL produce no detects.
REQ-017 The sync chain and history flop SHALL update every cycle regardless of mode, so a mode change never creates a spurious detect.
REQ-018 A mode change SHALL take effect on the first rising edge at which the new value is sampled.
REQ-019 Latency: if E0 is the first edge sampling d[i] at its new level, pulse[i] SHALL be high for exactly the one cycle following edge E0+SYNC_STAGES.
REQ-020 Input levels held for at least one full clk period SHALL never be missed; shorter pulses are not guaranteed.
REQ-021 Stretcher: each detect SHALL load a per-channel down-counter with STRETCH; stretch[i] SHALL be high while that counter is nonzero, starting in the same cycle as pulse[i].
REQ-022 A detect while stretch[i] is active SHALL reload the counter to STRETCH (retrigger, no gap).
REQ-023 Stretch counters SHALL continue to decrement while mode=11.
REQ-024 Each detect SHALL set sticky[i]; clr[i] SHALL clear it; a simultaneous clr[i] and detect SHALL leave sticky[i]=1.
REQ-025 Each detect SHALL increment cnt channel i, saturating at 2^CNT_W-1 with no wrap.
REQ-026 clr[i] SHALL zero cnt channel i; a simultaneous clr[i] and detect SHALL yield a count of 1.
REQ-027 Channels SHALL be fully independent; activity on one channel SHALL never alter another.

Reset
REQ-028 With reset high at a clk edge, the sync chains, history flops, pulse, stretch counters, sticky, and cnt SHALL all become 0, and busy SHALL become 0.
REQ-029 Reset SHALL take priority over detect and clr, including mid-stretch.
REQ-030 A d[i] held high across reset release SHALL produce one rising detect at SYNC_STAGES edges after release (modes 00 and 10).

Configuration
REQ-031 With macro PULSE_CAPTURE_CNT_EN defined, the event counters SHALL be built as specified above.
REQ-032 Without PULSE_CAPTURE_CNT_EN, no counter flops SHALL exist and cnt SHALL be driven constant 0; all other behaviour SHALL be unchanged.

Verification
Default parameters apply below.
REQ-033 Bench SHALL cover: reset for 12 time units, then d[0] high for one clk, mode=00 -> pulse[0] high for 1 cycle, 2 edges after first sample; stretch[0] high for 3 cycles; sticky[0]=1; cnt0=1.
REQ-034 Bench SHALL cover: same stimulus with mode=01 -> single detect, aligned to the falling transition; with mode=10 -> two detects and cnt0=2; with mode=11 -> no detect and cnt0=0.
REQ-035 Bench SHALL cover: d[1] toggled high/low (one cycle each) 300 times, mode=00 -> cnt1=255 (saturated), sticky[1]=1, stretch[1] continuously high during the burst.
REQ-036 Bench SHALL cover: clr[2] asserted in the same cycle as the ch2 pulse strobe -> sticky[2]=1, cnt2=1; clr[2] alone afterwards -> sticky[2]=0, cnt2=0.
REQ-037 Bench SHALL cover: reset asserted while stretch[3]=1 with cnt3=5 -> after the next edge, all outputs are 0 and busy=0.
REQ-038 Bench SHALL cover: build without PULSE_CAPTURE_CNT_EN, rerun REQ-033 -> cnt=0, with pulse, stretch, and sticky identical to REQ-033.
